// File: rtl/snes_pad_responder.sv
// ---------------------------------------------------------------------------
// snes_pad_responder
//   Device side of the SNES controller serial link. Emulates a pad toward a
//   host console or fixture: captures the button state while the host holds
//   latch high, then shifts the 16-bit frame out LSB first, one bit per
//   host clock rising edge. Data on the wire is active-low (0 = pressed).
//
//   Host latch/clock are asynchronous; each passes through SYNC_STAGES
//   flops plus one edge-detect flop, so a host edge affects the registered
//   outputs SYNC_STAGES+1 clock cycles later.
//
// Ports
//   clock          system clock (cpu_clock domain)
//   rst            synchronous, active-low reset
//   buttons[11:0]  pressed = 1; [0]B [1]Y [2]Sel [3]Start [4]Up [5]Down
//                  [6]Left [7]Right [8]A [9]X [10]L [11]R
//   snes_latch_in  host latch, active-high, asynchronous
//   snes_clock_in  host shift clock, idles high, asynchronous
//   snes_data_out  serial data, active-low
//   busy           high while a frame is latched or shifting
//   frame_done     one-cycle pulse after the last bit has been shifted
//   bit_count      index of the bit currently on snes_data_out
//
// Optional feature (macro SNES_RESP_TIMEOUT_EN): abandon a frame that has
//   seen no host clock edge for TIMEOUT_CYCLES cycles while shifting.
// ---------------------------------------------------------------------------
module snes_pad_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [11:0] buttons,
  input  logic        snes_latch_in,
  input  logic        snes_clock_in,
  output logic        snes_data_out,
  output logic        busy,
  output logic        frame_done,
  output logic [4:0]  bit_count
);

  typedef enum logic [1:0] {IDLE, LATCHED, SHIFT, DONE} state_t;

  localparam logic [4:0] LAST_BIT = 5'(NUM_BITS);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   latch_prev_q;
  logic                   clk_prev_q;
  logic [NUM_BITS-1:0]    shift_q;
  logic                   busy_q;
  logic                   done_q;
  logic [4:0]             cnt_q;

  logic                   latch_s;
  logic                   clk_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   clk_rise;
  logic [NUM_BITS-1:0]    load_d;
  logic [NUM_BITS-1:0]    shift_d;
  logic [4:0]             cnt_d;

`ifdef SNES_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_q;
  logic          clk_fall;
`endif

  // Synchronizers and edge-detect flops. Reset to the idle line levels so
  // leaving reset never looks like a host edge.
  always_ff @(posedge clock) begin
    if (!rst) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '1;
      latch_prev_q <= 1'b0;
      clk_prev_q   <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], snes_latch_in};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], snes_clock_in};
      latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
      clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev_q;
  assign latch_fall = ~latch_s & latch_prev_q;
  assign clk_rise   = clk_s & ~clk_prev_q;
`ifdef SNES_RESP_TIMEOUT_EN
  assign clk_fall   = ~clk_s & clk_prev_q;
`endif

  // Frame image: pad ID bits above the buttons stay 1, buttons inverted.
  always_comb begin
    load_d        = '1;
    load_d[11:0]  = ~buttons;
  end

  // Zero fill so the line sits low once the whole frame has been shifted.
  assign shift_d = {1'b0, shift_q[NUM_BITS-1:1]};
  assign cnt_d   = cnt_q + 5'd1;

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 5'd0;
`ifdef SNES_RESP_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (latch_s) begin
            state_q <= LATCHED;
            shift_q <= load_d;
            busy_q  <= 1'b1;
            cnt_q   <= 5'd0;
          end
        end
        LATCHED: begin
          // Keep tracking buttons so the value at latch fall is captured.
          shift_q <= load_d;
          cnt_q   <= 5'd0;
`ifdef SNES_RESP_TIMEOUT_EN
          to_q    <= '0;
`endif
          if (latch_fall) state_q <= SHIFT;
        end
        SHIFT: begin
          // A new latch outranks a simultaneous clock edge.
          if (latch_rise) begin
            state_q <= LATCHED;
            shift_q <= load_d;
            cnt_q   <= 5'd0;
          end else if (clk_rise) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef SNES_RESP_TIMEOUT_EN
            to_q    <= '0;
`endif
            if (cnt_d == LAST_BIT) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
`ifdef SNES_RESP_TIMEOUT_EN
          else if (clk_fall) begin
            to_q <= '0;
          end else if (to_q == TO_LAST) begin
            state_q <= IDLE;
            shift_q <= '1;
            busy_q  <= 1'b0;
            cnt_q   <= 5'd0;
            to_q    <= '0;
          end else begin
            to_q <= to_q + 1'b1;
          end
`endif
        end
        DONE: begin
          if (latch_s) begin
            state_q <= LATCHED;
            shift_q <= load_d;
            busy_q  <= 1'b1;
            cnt_q   <= 5'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign snes_data_out = shift_q[0];
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign bit_count     = cnt_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// ---------------------------------------------------------------------------
// Bench for snes_pad_responder: acts as the host console, drives directed
// and random latch/clock sequences and checks every output each cycle
// against a protocol-level model, plus literal expectations for the
// standard frames.
// ---------------------------------------------------------------------------
module tb_snes_pad_responder;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic [11:0] buttons = 12'h000;
  logic        lat  = 1'b0;
  logic        sclk = 1'b1;
  logic        data;
  logic        busy;
  logic        fd;
  logic [4:0]  bc;

  snes_pad_responder #(
    .SYNC_STAGES   (2),
    .NUM_BITS      (16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .buttons      (buttons),
    .snes_latch_in(lat),
    .snes_clock_in(sclk),
    .snes_data_out(data),
    .busy         (busy),
    .frame_done   (fd),
    .bit_count    (bc)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- protocol model ----------------
  // Host lines reach the protocol logic two samples late; edges compare
  // that delayed level with the one before it.
  localparam int M_IDLE = 0, M_LAT = 1, M_SHIFT = 2, M_DONE = 3;
  bit          lq[$];
  bit          cq[$];
  int          mode = M_IDLE;
  logic [11:0] frame = 12'h000;
  int          pos = 0;
  int          tcnt = 0;
  bit          mv = 0;
  int          cyc = 0;
  bit          e_data = 1, e_busy = 0, e_fd = 0;
  int          e_bc = 0;
  int          fd_cnt = 0;
  int          fd_cyc = 0;

  always @(posedge clock) begin
    bit sl, pl, sc, pc, lr, lf, cr, cf;
    cyc++;
    if (!rst) begin
      lq = '{0, 0, 0};
      cq = '{1, 1, 1};
      mode = M_IDLE;
      pos = 0;
      tcnt = 0;
      e_fd = 0;
      mv = 1;
    end else begin
      sl = lq[1]; pl = lq[0];
      sc = cq[1]; pc = cq[0];
      lr = sl && !pl; lf = !sl && pl;
      cr = sc && !pc; cf = !sc && pc;
      e_fd = 0;
      case (mode)
        M_IDLE, M_DONE: if (sl) begin mode = M_LAT; frame = buttons; pos = 0; end
        M_LAT: begin
          frame = buttons;
          if (lf) begin mode = M_SHIFT; pos = 0; tcnt = 0; end
        end
        default: begin
          if (lr) begin
            mode = M_LAT; frame = buttons; pos = 0;
          end else if (cr) begin
            pos++;
            tcnt = 0;
            if (pos == 16) begin mode = M_DONE; e_fd = 1; end
          end
`ifdef SNES_RESP_TIMEOUT_EN
          else if (cf) tcnt = 0;
          else begin
            tcnt++;
            if (tcnt >= TO) begin mode = M_IDLE; pos = 0; end
          end
`endif
        end
      endcase
      lq.push_back(lat);  void'(lq.pop_front());
      cq.push_back(sclk); void'(cq.pop_front());
    end
    case (mode)
      M_IDLE:  e_data = 1;
      M_DONE:  e_data = 0;
      default: e_data = (pos < 12) ? !frame[pos] : (pos < 16);
    endcase
    e_busy = (mode == M_LAT) || (mode == M_SHIFT);
    e_bc   = pos;
  end

  always @(negedge clock) begin
    if (mv) begin
      chk("data", int'(data), int'(e_data));
      chk("busy", int'(busy), int'(e_busy));
      chk("frame_done", int'(fd), int'(e_fd));
      chk("bit_count", int'(bc), e_bc);
      if (fd) begin fd_cnt++; fd_cyc = cyc; end
    end
  end

  // ---------------- host stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic host_frame(input logic [11:0] b, input int np, input int w,
                            output logic [31:0] s, output int rise_cyc);
    s = '0;
    rise_cyc = 0;
    buttons = b;
    lat = 1'b1; tick(2 * w);
    lat = 1'b0; tick(w);
    for (int i = 0; i < np; i++) begin
      sclk = 1'b0; tick(w);
      s[i] = data;
      sclk = 1'b1;
      rise_cyc = cyc;
      tick(w);
    end
  endtask

  initial begin
    logic [31:0] s;
    int rc, f0;

    rst = 1'b0; tick(2);
    rst = 1'b1; tick(1);
    chk("reset data", int'(data), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset bit_count", int'(bc), 0);
    chk("reset frame_done", int'(fd), 0);

    // B pressed
    f0 = fd_cnt;
    host_frame(12'h001, 16, 24, s, rc);
    chk("B frame bits", int'(s[15:0]), 16'hFFFE);
    chk("B frame_done count", fd_cnt - f0, 1);
    chk("B frame_done latency", fd_cyc - rc, 3);
    chk("B data after", int'(data), 0);
    chk("B bit_count after", int'(bc), 16);

    // mixed pattern
    host_frame(12'hA5A, 16, 24, s, rc);
    chk("A5A frame bits", int'(s[15:0]), 16'hF5A5);

    // abort after 5 clocks, then a full frame with nothing pressed
    f0 = fd_cnt;
    buttons = 12'hFFF;
    lat = 1'b1; tick(48);
    lat = 1'b0; tick(24);
    repeat (5) begin sclk = 1'b0; tick(24); sclk = 1'b1; tick(24); end
    host_frame(12'h000, 16, 24, s, rc);
    chk("abort frame bits", int'(s[15:0]), 16'hFFFF);
    chk("abort frame_done count", fd_cnt - f0, 1);

    // extra clocks
    f0 = fd_cnt;
    host_frame(12'h001, 20, 8, s, rc);
    chk("extra clocks bits", int'(s[19:0]), 20'h0FFFE);
    chk("extra clocks bit_count", int'(bc), 16);
    chk("extra clocks data", int'(data), 0);
    chk("extra clocks frame_done count", fd_cnt - f0, 1);

    // reset mid-frame, then no fresh latch
    buttons = 12'h0F0;
    lat = 1'b1; tick(10); lat = 1'b0; tick(6);
    repeat (3) begin sclk = 1'b0; tick(5); sclk = 1'b1; tick(5); end
    rst = 1'b0; tick(2);
    chk("midreset data", int'(data), 1);
    chk("midreset busy", int'(busy), 0);
    chk("midreset bit_count", int'(bc), 0);
    rst = 1'b1; tick(10);
    chk("after reset busy", int'(busy), 0);

`ifdef SNES_RESP_TIMEOUT_EN
    f0 = fd_cnt;
    buttons = 12'h003;
    lat = 1'b1; tick(10); lat = 1'b0; tick(6);
    repeat (3) begin sclk = 1'b0; tick(5); sclk = 1'b1; tick(5); end
    tick(72);
    chk("timeout data", int'(data), 1);
    chk("timeout bit_count", int'(bc), 0);
    chk("timeout busy", int'(busy), 0);
    chk("timeout frame_done count", fd_cnt - f0, 0);
`endif

    // random host behaviour, checked cycle by cycle against the model
    for (int r = 0; r < 120; r++) begin
      buttons = 12'($urandom);
      lat = 1'b1; tick($urandom_range(1, 6));
      lat = 1'b0;
      if ($urandom_range(0, 3) == 0) buttons = 12'($urandom);
      tick($urandom_range(1, 5));
      for (int p = 0, n = $urandom_range(0, 20); p < n; p++) begin
        sclk = 1'b0; tick($urandom_range(1, 5));
        if ($urandom_range(0, 5) == 0) buttons = 12'($urandom);
        sclk = 1'b1;
        if ($urandom_range(0, 30) == 0) lat = 1'b1;
        tick($urandom_range(1, 5));
        lat = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) tick(80);
      if ($urandom_range(0, 19) == 0) begin rst = 1'b0; tick($urandom_range(1, 3)); rst = 1'b1; end
      tick($urandom_range(1, 8));
    end

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
- Device-side end of the SNES controller serial protocol. It emulates a SNES pad toward an external host console or test fixture.
- Receives the host's latch and clock lines and shifts out a 16-bit button frame on the data line.
- Runs on the ~4 MHz cpu_clock domain. Host latch and clock are asynchronous to it and are synchronized internally.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on snes_latch_in and snes_clock_in (minimum 2).
- NUM_BITS, 16, number of bits shifted per frame.
- TIMEOUT_CYCLES, 4096, idle cycles in SHIFT before the frame is abandoned (used only with the optional feature).

Ports:
- clock  input  1  system clock (cpu_clock domain).
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- buttons  input  12  button state, active-high pressed. Bit order: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R.
- snes_latch_in  input  1  host latch, active-high, asynchronous.
- snes_clock_in  input  1  host shift clock, idles high, asynchronous.
- snes_data_out  output  1  serial data, active-low (0 = pressed).
- busy  output  1  high in LATCHED or SHIFT.
- frame_done  output  1  one-cycle pulse when the last bit has been shifted out.
- bit_count  output  5  index of the bit currently on snes_data_out (0..NUM_BITS).

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, shift register all 1s, snes_data_out=1, busy=0, frame_done=0, bit_count=0.
  - Synchronizer flops are reset to latch=0, clock=1.
- Sync and edge detect: SYNC_STAGES flops followed by one edge-detect flop per input. A host edge therefore reaches internal logic SYNC_STAGES+1 cycles later (3 with default).
- Frame load value: {4'b1111, ~buttons}, with bit0 first. Bits 12..15 are always 1 (standard pad ID).
- State machine:
  - IDLE: on synced latch=1, go to LATCHED.
  - LATCHED: every cycle, reload the shift register from buttons, so the last value before latch fall is the one captured. snes_data_out = ~buttons[0]; bit_count=0. Clock edges are ignored. On synced latch falling edge, go to SHIFT.
  - SHIFT: on synced snes_clock_in rising edge, shift right, fill the MSB with 0, and increment bit_count. snes_data_out always equals shift register bit 0.
    - When bit_count reaches NUM_BITS: pulse frame_done and go to DONE.
    - snes_data_out is then 0 (the real pad drives low after 16 bits).
  - DONE: hold snes_data_out=0, busy=0. On synced latch=1, go to LATCHED.
- Falling edges of snes_clock_in have no effect in any state.
- Latch rising while in SHIFT: abort the frame and go to LATCHED. frame_done is not pulsed.
- Clock rising edge and latch rising edge detected in the same cycle: latch wins and the shift is discarded.
- More clock edges than NUM_BITS: extra edges in DONE are ignored; data stays 0 and bit_count saturates at NUM_BITS.
- buttons changes while in SHIFT: no effect on the current frame.
- Reset mid-frame: immediate return to reset values; the next frame needs a fresh latch.
- Outputs are registered. No combinational path exists from any input to snes_data_out.

Optional Feature:
- Macro: SNES_RESP_TIMEOUT_EN.
- Defined: a counter clears on every synced clock edge and on entry to SHIFT. If it reaches TIMEOUT_CYCLES while in SHIFT:
  - state goes to IDLE;
  - shift register goes to all 1s, snes_data_out=1, bit_count=0;
  - frame_done is not pulsed.
- Not defined: no counter; SHIFT waits indefinitely for clock edges.

Test Plan:
- Reset held 2 cycles, then released with inputs idle -> snes_data_out=1, busy=0, bit_count=0, frame_done=0.
- buttons=12'h001 (B), latch pulse of 48 cycles, then 16 clock pulses (24 cycles low / 24 high) -> host samples 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1; frame_done pulses once, 3 cycles after the 16th rising edge; data=0 afterwards.
- buttons=12'hA5A, full frame -> sampled bits 12 and 15 both 1; bits 0..11 equal ~12'hA5A LSB first (1,0,1,0,0,1,0,1,1,0,1,0).
- Frame started with buttons=12'hFFF, latch re-asserted after 5 clocks with buttons=12'h000 -> frame_done not pulsed; next frame reads all 1s.
- 20 clock pulses after latch -> pulses 17..20 ignored; bit_count=16, data=0, a single frame_done.
- With SNES_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=64: latch, 3 clocks, then silence -> within 64 cycles of the last edge state=IDLE, data=1, bit_count=0, no frame_done.
